demux_rr_dispatcher: RTL and testbench
======================================

# demux_rr_dispatcher

Sequencing controller for the 1-to-4 demultiplexer datapath. It accepts words from a single upstream valid/ready stream, holds each word in a one-entry register, and steers it to one of four downstream channels. Channel choice is round-robin over the currently enabled channels. The block also counts delivered words per channel and sits between a shared producer and four consumer lanes.

## Interface
- DATA_W, 8, width of data word
- CNT_W, 8, width of each per-channel delivery counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word this cycle
- din  input  DATA_W  upstream data
- chan_en  input  4  per-channel enable mask, bit i = channel i
- out_valid  output  4  one-hot valid toward channel i (0000 when idle)
- out_ready  input  4  per-channel ready from consumer i
- dout  output  DATA_W  held word, shared by all four channels
- sel  output  2  channel currently targeted (valid when out_valid != 0)
- cnt_clr  input  1  synchronous clear of all delivery counters
- cnt  output  4*CNT_W  delivery counters, channel i at bits [i*CNT_W +: CNT_W]

## Operation
- The FSM has two states: IDLE and SEND.
- The rotating pointer ptr[1:0] is the first channel considered at the next acceptance.
- IDLE:
  - in_ready = (chan_en != 0); it is combinational from state and chan_en.
  - On in_valid & in_ready: latch din into dout.
  - Set sel = the first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with chan_en[i] = 1.
  - Go to SEND.
- SEND:
  - in_ready = 0.
  - out_valid = 4'b0001 << sel.
  - dout and sel are held stable.
  - On out_ready[sel]: cnt[sel] += 1, ptr = sel + 1 (mod 4), go to IDLE.
  - out_ready on non-selected channels is ignored.
- chan_en = 0 in IDLE: in_ready = 0 and the upstream stalls. No word is dropped.
- A chan_en change during SEND does not affect the committed word. It is delivered to sel even if chan_en[sel] drops. The new mask applies from the next acceptance.
- Counters are unsigned and wrap from 2^CNT_W-1 to 0.
- cnt_clr zeroes all four counters at the next edge. If a delivery increment coincides with cnt_clr, the clear wins and the counter reads 0.
- dout keeps the last delivered word while in IDLE.

## Timing
- Reset (async assert, rst_n low): state = IDLE, ptr = 0, sel = 0, dout = 0, out_valid = 0000, all cnt = 0. in_ready follows chan_en once state is IDLE.
- Acceptance at edge N gives out_valid high in cycle N+1 (1-cycle latency).
- Delivery at edge M (out_valid[sel] & out_ready[sel]):
  - out_valid = 0000 in cycle M+1.
  - cnt updated and visible in cycle M+1.
  - in_ready can be high in cycle M+1.
- Maximum throughput is 1 word per 2 cycles. There is no acceptance while in SEND.
- Backpressure: out_valid, dout and sel are held indefinitely while out_ready[sel] = 0.
- Reset mid-SEND: out_valid drops to 0000 immediately (asynchronous). The held word is discarded and ptr returns to 0.

## Test plan
- Reset values:
  - Stimulus: rst_n low with chan_en = 1111.
  - Response: out_valid = 0000, dout = 0, sel = 0, all cnt = 0. After release, in_ready = 1 in IDLE.
- Round-robin, all enabled:
  - Stimulus: chan_en = 1111, out_ready = 1111, words 0xA0..0xA4.
  - Response: delivered on channels 0, 1, 2, 3, 0 in that order. out_valid is one cycle after each accept, and cnt = {1,1,1,2} for channels {3,2,1,0}.
- Skip disabled channels:
  - Stimulus: chan_en = 1010, three words.
  - Response: sel = 1, 3, 1. cnt[0] and cnt[2] stay 0.
  - Stimulus: then chan_en = 0000.
  - Response: in_ready = 0 and in_valid held high is not accepted.
- Backpressure:
  - Stimulus: accept 0x5C to channel 2; hold out_ready[2] = 0 for 3 cycles with out_ready to the other channels = 1.
  - Response: out_valid = 0100, dout = 0x5C and in_ready = 0 throughout. Delivery occurs on the cycle out_ready[2] = 1. Clearing chan_en[2] mid-SEND still delivers to channel 2.
- Counter wrap and clear:
  - Stimulus: drive cnt[0] to 255, then one more delivery on channel 0.
  - Response: cnt[0] = 0.
  - Stimulus: assert cnt_clr on the same edge as a channel-1 delivery.
  - Response: cnt[1] = 0.
- Reset mid-operation:
  - Stimulus: assert rst_n low during SEND with out_ready = 0.
  - Response: out_valid = 0000 without waiting for a clock edge. After release, the next word goes to channel 0.

Source files
------------

// File: rtl/demux_rr_dispatcher_if.sv
// Stream bundle between the shared producer, the dispatcher and the four consumer lanes.
// The dispatcher takes the slave view; the environment drives through the master view.
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] dout;
  logic [1:0]        sel;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, sel
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, sel
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// One-entry 1-to-4 dispatcher: accepts a word, steers it round-robin over the enabled
// channels, and counts deliveries per channel.
module demux_rr_dispatcher #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_rr_dispatcher_if.slave bus,
  input  logic [3:0]           chan_en_i,
  input  logic                 cnt_clr_i,
  output logic [4*CNT_W-1:0]   cnt_o
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q;
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] dout_q;
  logic [CNT_W-1:0]  cnt_q [4];

  logic [1:0]        pick_sel;
  logic              accept;
  logic              deliver;

  // First enabled channel at or after ptr; scanning offsets downward lets the smallest win.
  always_comb begin
    pick_sel = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (chan_en_i[ptr_q + 2'(k)]) begin
        pick_sel = ptr_q + 2'(k);
      end
    end
  end

  assign accept  = (state_q == IDLE) && bus.in_valid && (chan_en_i != 4'b0000);
  assign deliver = (state_q == SEND) && bus.out_ready[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = SEND;
      SEND:    if (deliver) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 4'b0000;
    case (state_q)
      IDLE:    bus.in_ready  = (chan_en_i != 4'b0000);
      SEND:    bus.out_valid = 4'b0001 << sel_q;
      default: ;
    endcase
  end

  // The target is committed at acceptance, so later mask changes cannot redirect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      sel_q  <= 2'd0;
      ptr_q  <= 2'd0;
    end else begin
      if (accept) begin
        dout_q <= bus.din;
        sel_q  <= pick_sel;
      end
      if (deliver) begin
        ptr_q <= sel_q + 2'd1;
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.sel  = sel_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[gi] <= '0;
      end else if (cnt_clr_i) begin
        cnt_q[gi] <= '0;
      end else if (deliver && (sel_q == 2'(gi))) begin
        cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end
    end
    assign cnt_o[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a transaction-level model of the dispatcher.
module tb_demux_rr_dispatcher;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         chan_en = 4'b1111;
  logic               cnt_clr = 1'b0;
  logic [4*CNT_W-1:0] cnt;

  demux_rr_dispatcher_if #(.DATA_W(DATA_W)) bus ();

  demux_rr_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .chan_en_i (chan_en),
    .cnt_clr_i (cnt_clr),
    .cnt_o     (cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whether a word is held, where it is going, and the rotation start.
  bit         m_busy;
  int         m_ptr;
  int         m_tgt;
  logic [7:0] m_held;
  int         m_cnt [4];
  int         deliv_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_tgt  = 0;
    m_held = 8'h00;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  // Apply inputs for one cycle, check outputs mid-cycle, then advance model and DUT together.
  task automatic step(input bit v, input logic [7:0] d, input logic [3:0] en,
                      input logic [3:0] rdy, input bit clr);
    bus.in_valid  = v;
    bus.din       = d;
    bus.out_ready = rdy;
    chan_en       = en;
    cnt_clr       = clr;
    #3;
    check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_busy && en != 4'b0000)});
    check_eq("out_valid", {28'd0, bus.out_valid}, m_busy ? (32'd1 << m_tgt) : 32'd0);
    check_eq("dout", {24'd0, bus.dout}, {24'd0, m_held});
    if (m_busy) check_eq("sel", {30'd0, bus.sel}, m_tgt);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("cnt%0d", i), {24'd0, cnt[i*CNT_W +: CNT_W]}, m_cnt[i]);

    if (!m_busy) begin
      if (v && en != 4'b0000) begin
        m_held = d;
        for (int k = 0; k < 4; k++) begin
          if (en[(m_ptr + k) % 4]) begin
            m_tgt = (m_ptr + k) % 4;
            break;
          end
        end
        m_busy = 1'b1;
      end
    end else if (rdy[m_tgt]) begin
      m_cnt[m_tgt] = (m_cnt[m_tgt] + 1) % 256;
      m_ptr  = (m_tgt + 1) % 4;
      m_busy = 1'b0;
      deliv_q.push_back(m_tgt);
      $display("deliver ch%0d data 0x%02h", m_tgt, m_held);
    end
    if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;

    @(posedge clk);
    #1;
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};
  int exp_sk [3] = '{1, 3, 1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 4'b0000;
    model_reset();

    // Reset values
    #2;
    check_eq("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check_eq("rst_dout", {24'd0, bus.dout}, 32'd0);
    check_eq("rst_sel", {30'd0, bus.sel}, 32'd0);
    check_eq("rst_cnt", cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 8'h00, 4'b1111, 4'b1111, 0);

    // Round-robin with all channels enabled
    deliv_q.delete();
    for (int w = 0; w < 5; w++) begin
      step(1, 8'hA0 + 8'(w), 4'b1111, 4'b1111, 0);
      check_eq("rr_latency", {28'd0, bus.out_valid}, 32'd1 << exp_rr[w]);
      step(0, 8'h00, 4'b1111, 4'b1111, 0);
    end
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("rr_order%0d", k), deliv_q.size() > k ? deliv_q[k] : -1, exp_rr[k]);
    check_eq("rr_cnt", cnt, {8'd1, 8'd1, 8'd1, 8'd2});

    // Skip disabled channels, then a fully disabled mask stalls upstream
    step(0, 8'h00, 4'b1010, 4'b0000, 1);
    deliv_q.delete();
    for (int w = 0; w < 3; w++) begin
      step(1, 8'h30 + 8'(w), 4'b1010, 4'b1111, 0);
      step(0, 8'h00, 4'b1010, 4'b1111, 0);
    end
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("skip_order%0d", k), deliv_q.size() > k ? deliv_q[k] : -1, exp_sk[k]);
    check_eq("skip_cnt0", {24'd0, cnt[0 +: 8]}, 32'd0);
    check_eq("skip_cnt2", {24'd0, cnt[16 +: 8]}, 32'd0);
    for (int c = 0; c < 3; c++) step(1, 8'hEE, 4'b0000, 4'b1111, 0);
    check_eq("stall_no_accept", {28'd0, bus.out_valid}, 32'd0);

    // Backpressure on channel 2, mask change mid-SEND
    step(1, 8'h5C, 4'b1111, 4'b1111, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 8'h00, (c == 2) ? 4'b1011 : 4'b1111, 4'b1011, 0);
      check_eq("bp_out_valid", {28'd0, bus.out_valid}, 32'h4);
      check_eq("bp_dout", {24'd0, bus.dout}, 32'h5C);
      check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    deliv_q.delete();
    step(0, 8'h00, 4'b1011, 4'b0100, 0);
    check_eq("bp_deliver_ch", deliv_q.size() == 1 ? deliv_q[0] : -1, 32'd2);

    // Counter wrap on channel 0
    for (int w = 0; w < 255; w++) begin
      step(1, 8'(w), 4'b0001, 4'b0001, 0);
      step(0, 8'h00, 4'b0001, 4'b0001, 0);
    end
    check_eq("wrap_255", {24'd0, cnt[0 +: 8]}, 32'd255);
    step(1, 8'hFF, 4'b0001, 4'b0001, 0);
    step(0, 8'h00, 4'b0001, 4'b0001, 0);
    check_eq("wrap_0", {24'd0, cnt[0 +: 8]}, 32'd0);

    // Clear coinciding with a channel-1 delivery
    step(1, 8'h11, 4'b0010, 4'b0000, 0);
    step(0, 8'h00, 4'b0010, 4'b0000, 0);
    check_eq("clr_pre_cnt1", {24'd0, cnt[8 +: 8]}, 32'd2);
    step(0, 8'h00, 4'b0010, 4'b1111, 1);
    check_eq("clr_cnt1", {24'd0, cnt[8 +: 8]}, 32'd0);

    // Asynchronous reset mid-SEND
    step(1, 8'h77, 4'b1111, 4'b0000, 0);
    step(0, 8'h00, 4'b1111, 4'b0000, 0);
    check_eq("pre_rst_busy", {31'd0, bus.out_valid != 4'b0000}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    deliv_q.delete();
    step(1, 8'h88, 4'b1111, 4'b1111, 0);
    step(0, 8'h00, 4'b1111, 4'b1111, 0);
    check_eq("post_rst_ch", deliv_q.size() == 1 ? deliv_q[0] : -1, 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(bit'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
           4'($urandom), bit'($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
